// File: rtl/score_ctrl_pkg.sv
// Shared definitions for the score table controller.
// Holds the controller state encoding and the saturating add used on the
// read-modify-write path.
package score_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RMW_RD  = 3'd1,
        RMW_CAP = 3'd2,
        RMW_WR  = 3'd3,
        CLR     = 3'd4
    } state_t;

    // Widest score entry the saturating add supports.
    localparam int unsigned SAT_MAX_W = 32;

    // Add two w-bit operands (zero-extended to SAT_MAX_W) and clamp to all-ones
    // of width w on overflow. Operands below 2**w overflow exactly when the
    // (w+1)-bit sum carries.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int unsigned          w
    );
        logic [SAT_MAX_W:0] sum;
        logic [SAT_MAX_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
        sat_add = (sum > lim) ? lim[SAT_MAX_W-1:0] : sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/score_table_ctrl.sv
// Sequencer/arbiter for the single-port score SRAM.
// Display reads get the port unconditionally (fixed 1-cycle latency); the FSM
// performs saturating read-modify-write adds and a whole-table clear in the
// remaining cycles.
// Ports:
//   clk, reset                 clock, async active-high reset
//   disp_req/disp_idx          display read request (any cycle)
//   disp_valid/disp_data       display read response, 1 cycle later
//   add_req/add_idx/add_val    add request, accepted while add_ready
//   add_ready                  controller idle
//   add_done/add_result        write-back pulse and value written
//   clear_req/clear_busy       table clear request and progress flag
//   sram_*                     SRAM port (combinational from state + requests)
module score_table_ctrl
    import score_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TBL_AW     = 4,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  disp_req,
    input  logic [TBL_AW-1:0]     disp_idx,
    output logic                  disp_valid,
    output logic [DATA_WIDTH-1:0] disp_data,
    input  logic                  add_req,
    input  logic [TBL_AW-1:0]     add_idx,
    input  logic [DATA_WIDTH-1:0] add_val,
    output logic                  add_ready,
    output logic                  add_done,
    output logic [DATA_WIDTH-1:0] add_result,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    state_t                r_state;
    state_t                w_next;
    logic [TBL_AW-1:0]     r_idx;
    logic [TBL_AW-1:0]     r_clr_idx;
    logic [DATA_WIDTH-1:0] r_val;
    logic [DATA_WIDTH-1:0] r_old;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_disp_pend;

    logic                  w_fsm_en;
    logic                  w_fsm_we;
    logic [TBL_AW-1:0]     w_fsm_idx;
    logic [DATA_WIDTH-1:0] w_fsm_wdata;
    logic                  w_latch_add;
    logic                  w_clr_start;
    logic                  w_clr_step;
    logic                  w_wr_done;
    logic [DATA_WIDTH-1:0] w_new;

    assign w_new = DATA_WIDTH'(sat_add(SAT_MAX_W'(r_old), SAT_MAX_W'(r_val), DATA_WIDTH));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and planned FSM access; any planned access stalls on disp_req
    always_comb begin
        w_next      = r_state;
        w_fsm_en    = 1'b0;
        w_fsm_we    = 1'b0;
        w_fsm_idx   = '0;
        w_fsm_wdata = '0;
        w_latch_add = 1'b0;
        w_clr_start = 1'b0;
        w_clr_step  = 1'b0;
        w_wr_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (clear_req) begin
                    w_clr_start = 1'b1;
                    w_next      = CLR;
                end else if (add_req) begin
                    w_latch_add = 1'b1;
                    w_next      = RMW_RD;
                end
            end
            RMW_RD: begin
                w_fsm_en  = 1'b1;
                w_fsm_idx = r_idx;
                if (!disp_req) w_next = RMW_CAP;
            end
            RMW_CAP: begin
                w_next = RMW_WR;
            end
            RMW_WR: begin
                w_fsm_en    = 1'b1;
                w_fsm_we    = 1'b1;
                w_fsm_idx   = r_idx;
                w_fsm_wdata = w_new;
                if (!disp_req) begin
                    w_wr_done = 1'b1;
                    w_next    = IDLE;
                end
            end
            CLR: begin
                w_fsm_en  = 1'b1;
                w_fsm_we  = 1'b1;
                w_fsm_idx = r_clr_idx;
                if (!disp_req) begin
                    w_clr_step = 1'b1;
                    if (r_clr_idx == '1) w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // SRAM port mux: display first, then the FSM
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (disp_req) begin
            sram_en   = 1'b1;
            sram_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(disp_idx);
        end else if (w_fsm_en) begin
            sram_en    = 1'b1;
            sram_we    = w_fsm_we;
            sram_addr  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(w_fsm_idx);
            sram_wdata = w_fsm_wdata;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp_pend <= 1'b0;
            r_idx       <= '0;
            r_val       <= '0;
            r_old       <= '0;
            r_result    <= '0;
            r_clr_idx   <= '0;
        end else begin
            r_disp_pend <= disp_req;
            if (w_latch_add) begin
                r_idx <= add_idx;
                r_val <= add_val;
            end
            if (r_state == RMW_CAP) r_old <= sram_rdata;
            if (w_wr_done) r_result <= w_new;
            if (w_clr_start) begin
                r_clr_idx <= '0;
            end else if (w_clr_step) begin
                r_clr_idx <= r_clr_idx + TBL_AW'(1);
            end
        end
    end

    assign add_ready  = (r_state == IDLE);
    assign clear_busy = (r_state == CLR);
    assign add_done   = w_wr_done;
    // Value is presented with the write-back pulse and held afterwards
    assign add_result = w_wr_done ? w_new : r_result;
    assign disp_valid = r_disp_pend;
    assign disp_data  = sram_rdata;

endmodule

// File: tb/tb_score_table_ctrl.sv
// Self-checking bench for score_table_ctrl with a behavioural 16-entry SRAM.
// Display responses are checked through an expected-data queue keyed by the
// cycle in which they must appear.
module tb_score_table_ctrl;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 16;
    localparam int unsigned TAW  = 4;
    localparam int unsigned NENT = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            disp_req;
    logic [TAW-1:0]  disp_idx;
    logic            disp_valid;
    logic [DW-1:0]   disp_data;
    logic            add_req;
    logic [TAW-1:0]  add_idx;
    logic [DW-1:0]   add_val;
    logic            add_ready;
    logic            add_done;
    logic [DW-1:0]   add_result;
    logic            clear_req;
    logic            clear_busy;
    logic            sram_en;
    logic            sram_we;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_wdata;
    logic [DW-1:0]   sram_rdata;

    score_table_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TBL_AW(TAW), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_idx(disp_idx),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .add_req(add_req), .add_idx(add_idx), .add_val(add_val),
        .add_ready(add_ready), .add_done(add_done), .add_result(add_result),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: registered read, write data echoed on the output; a backdoor
    // load port is used only while the controller leaves the port idle.
    logic [DW-1:0]  mem [NENT];
    logic           bd_we;
    logic [TAW-1:0] bd_idx;
    logic [DW-1:0]  bd_data;

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                mem[sram_addr[TAW-1:0]] <= sram_wdata;
                sram_rdata              <= sram_wdata;
            end else begin
                sram_rdata <= mem[sram_addr[TAW-1:0]];
            end
        end else if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [TAW-1:0] idx;
        logic [DW-1:0]  pre;
        logic [DW-1:0]  val;
        logic [DW-1:0]  res;
        bit             stall_rd;
    } vec_t;

    exp_t          sbq[$];
    logic [DW-1:0] exp_mem [NENT];
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle; sample #1 after the edge and retire due display reads.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sbq.size() != 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            chk("disp_valid", 32'(disp_valid), 32'd1);
            chk("disp_data", 32'(disp_data), 32'(e.data));
        end else begin
            chk("disp_valid_idle", 32'(disp_valid), 32'd0);
        end
    endtask

    task automatic preload(input logic [TAW-1:0] idx, input logic [DW-1:0] v);
        bd_we   = 1'b1;
        bd_idx  = idx;
        bd_data = v;
        exp_mem[idx] = v;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic disp_read(input logic [TAW-1:0] idx);
        disp_req = 1'b1;
        disp_idx = idx;
        #1;
        chk("disp_sram_en", 32'(sram_en), 32'd1);
        chk("disp_sram_we", 32'(sram_we), 32'd0);
        chk("disp_sram_addr", 32'(sram_addr), 32'(idx));
        sbq.push_back('{data: exp_mem[idx], cyc: cyc + 1});
        tick();
        disp_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_add_ready"}, 32'(add_ready), 32'd1);
        chk({tag, "_add_done"}, 32'(add_done), 32'd0);
        chk({tag, "_add_result"}, 32'(add_result), 32'd0);
        chk({tag, "_clear_busy"}, 32'(clear_busy), 32'd0);
        chk({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
        chk({tag, "_sram_en"}, 32'(sram_en), 32'd0);
        chk({tag, "_sram_we"}, 32'(sram_we), 32'd0);
        chk({tag, "_sram_addr"}, 32'(sram_addr), 32'd0);
        chk({tag, "_sram_wdata"}, 32'(sram_wdata), 32'd0);
    endtask

    // Issue an add, optionally stalling RMW_RD with one display read; returns
    // the cycle count from acceptance to add_done.
    task automatic do_add(input logic [TAW-1:0] idx, input logic [DW-1:0] val,
                          input bit stall_rd, output int lat);
        bit done;
        add_req = 1'b1;
        add_idx = idx;
        add_val = val;
        tick();
        add_req = 1'b0;
        chk("add_ready_busy", 32'(add_ready), 32'd0);
        if (stall_rd) begin
            disp_req = 1'b1;
            disp_idx = idx;
            sbq.push_back('{data: exp_mem[idx], cyc: cyc + 1});
        end
        lat  = 1;
        done = 1'b0;
        while (!done && lat < 12) begin
            tick();
            disp_req = 1'b0;
            #1;
            lat++;
            done = add_done;
        end
    endtask

    // Run a clear that was just requested; returns busy cycles and whether any
    // add_done was seen. An add_req is injected mid-clear.
    task automatic run_clear(output int n, output bit seen_done);
        n = 0;
        seen_done = 1'b0;
        while (clear_busy && n < 40) begin
            n++;
            if (n == 1) chk("clr_add_ready", 32'(add_ready), 32'd0);
            add_req = (n == 3);
            add_idx = 4'd2;
            add_val = 8'h01;
            tick();
            if (add_done) seen_done = 1'b1;
        end
        add_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (add_done) seen_done = 1'b1;
        end
        for (int i = 0; i < NENT; i++) exp_mem[i] = '0;
    endtask

    initial begin
        vec_t vecs[8];
        int   lat;
        int   n;
        bit   seen;

        vecs[0] = '{4'd5, 8'h10, 8'h05, 8'h15, 1'b0};
        vecs[1] = '{4'd0, 8'hFA, 8'h0A, 8'hFF, 1'b0};
        vecs[2] = '{4'd1, 8'h00, 8'hFF, 8'hFF, 1'b0};
        vecs[3] = '{4'd2, 8'h7F, 8'h80, 8'hFF, 1'b0};
        vecs[4] = '{4'd4, 8'h80, 8'h80, 8'hFF, 1'b1};
        vecs[5] = '{4'd6, 8'h01, 8'h02, 8'h03, 1'b1};
        vecs[6] = '{4'd7, 8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[7] = '{4'd8, 8'hFE, 8'h01, 8'hFF, 1'b0};

        reset     = 1'b1;
        disp_req  = 1'b0;
        disp_idx  = '0;
        add_req   = 1'b0;
        add_idx   = '0;
        add_val   = '0;
        clear_req = 1'b0;
        bd_we     = 1'b0;
        bd_idx    = '0;
        bd_data   = '0;
        for (int i = 0; i < NENT; i++) exp_mem[i] = '0;

        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();
        chk("rst_release_ready", 32'(add_ready), 32'd1);

        // Display latency, then back-to-back reads of two entries
        preload(4'd3, 8'h2A);
        preload(4'd9, 8'h5C);
        disp_read(4'd3);
        disp_read(4'd9);
        tick();

        // Table-driven adds
        foreach (vecs[k]) begin
            preload(vecs[k].idx, vecs[k].pre);
            do_add(vecs[k].idx, vecs[k].val, vecs[k].stall_rd, lat);
            chk($sformatf("add%0d_latency", k), 32'(lat), vecs[k].stall_rd ? 32'd4 : 32'd3);
            chk($sformatf("add%0d_result", k), 32'(add_result), 32'(vecs[k].res));
            tick();
            chk($sformatf("add%0d_done_pulse", k), 32'(add_done), 32'd0);
            chk($sformatf("add%0d_ready_back", k), 32'(add_ready), 32'd1);
            chk($sformatf("add%0d_result_held", k), 32'(add_result), 32'(vecs[k].res));
            exp_mem[vecs[k].idx] = vecs[k].res;
            disp_read(vecs[k].idx);
        end

        // Add stalled two cycles in RMW_WR by display reads of the same entry
        preload(4'd5, 8'h10);
        add_req = 1'b1;
        add_idx = 4'd5;
        add_val = 8'h05;
        tick();
        add_req = 1'b0;
        tick();
        tick();
        disp_req = 1'b1;
        disp_idx = 4'd5;
        sbq.push_back('{data: 8'h10, cyc: cyc + 1});
        #1;
        chk("wr_stall1_done", 32'(add_done), 32'd0);
        chk("wr_stall1_we", 32'(sram_we), 32'd0);
        tick();
        sbq.push_back('{data: 8'h10, cyc: cyc + 1});
        chk("wr_stall2_done", 32'(add_done), 32'd0);
        tick();
        disp_req = 1'b0;
        #1;
        chk("wr_stall_done_late", 32'(add_done), 32'd1);
        chk("wr_stall_result", 32'(add_result), 32'h15);
        chk("wr_stall_we", 32'(sram_we), 32'd1);
        chk("wr_stall_wdata", 32'(sram_wdata), 32'h15);
        tick();
        exp_mem[5] = 8'h15;
        disp_read(4'd5);

        // Clear with an add_req injected mid-sequence
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        run_clear(n, seen);
        chk("clr_busy_cycles", 32'(n), 32'd16);
        chk("clr_add_ignored", 32'(seen), 32'd0);
        for (int i = 0; i < NENT; i++) disp_read(TAW'(i));

        // clear_req and add_req together: clear wins, add dropped
        preload(4'd4, 8'h44);
        preload(4'd15, 8'h99);
        clear_req = 1'b1;
        add_req   = 1'b1;
        add_idx   = 4'd4;
        add_val   = 8'h01;
        tick();
        clear_req = 1'b0;
        add_req   = 1'b0;
        chk("same_cycle_busy", 32'(clear_busy), 32'd1);
        run_clear(n, seen);
        chk("same_cycle_busy_cycles", 32'(n), 32'd16);
        chk("same_cycle_no_done", 32'(seen), 32'd0);
        disp_read(4'd4);
        disp_read(4'd15);
        disp_read(4'd0);

        // Reset while in RMW_CAP aborts the add without write-back
        preload(4'd9, 8'h33);
        do_add(4'd3, 8'h07, 1'b0, lat);
        chk("pre_rst_result", 32'(add_result), 32'h07);
        exp_mem[3] = 8'h07;
        tick();
        add_req = 1'b1;
        add_idx = 4'd9;
        add_val = 8'h01;
        tick();
        add_req = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check_reset_outputs("midrmw");
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("midrmw_ready_after", 32'(add_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (add_done) seen = 1'b1;
        end
        chk("midrmw_no_done", 32'(seen), 32'd0);
        disp_read(4'd9);
        disp_read(4'd3);

        tick();
        tick();
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
